// File: rtl/input_debouncer_pkg.sv
// Shared helpers for input_debouncer: counter sizing, the legal STABLE_CYCLES
// range, and the per-bit pulse type passed from debounce_bit to the top.
package input_debouncer_pkg;

    localparam int unsigned STABLE_CYCLES_MIN = 1;
    localparam int unsigned STABLE_CYCLES_MAX = 32'd1 << 24;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    // Never returns 0, so an illegal STABLE_CYCLES still elaborates far enough to report it.
    function automatic int unsigned cnt_w(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit stable_cycles_ok(input int unsigned stable_cycles);
        return (stable_cycles >= STABLE_CYCLES_MIN) && (stable_cycles <= STABLE_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One debounced bit: counts consecutive samples that disagree with out and
// accepts the new level after STABLE_CYCLES of them, emitting a one-cycle pulse.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter logic        RESET_BIT     = 1'b0
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  in,
    output logic  out,
    output logic  rise,
    output logic  fall,
    output edge_t pulse_next
);

    localparam int unsigned CNT_W = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    if (!stable_cycles_ok(STABLE_CYCLES)) begin : g_bad_cfg
        $error("debounce_bit: STABLE_CYCLES=%0d outside 1..2^24", STABLE_CYCLES);
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             out_next;

    always_comb begin
        cnt_next   = cnt;
        out_next   = out;
        pulse_next = '0;
        if (in == out) begin
            cnt_next = '0;
        end else if (cnt == LAST) begin
            // Final differing sample: accept the level and restart from zero,
            // so the cycle after a pulse needs a fresh full run.
            out_next        = in;
            cnt_next        = '0;
            pulse_next.rise = in;
            pulse_next.fall = ~in;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            out  <= RESET_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            out  <= out_next;
            rise <= pulse_next.rise;
            fall <= pulse_next.fall;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Per-bit debouncer for synchronized inputs with rise/fall pulses and an event view.
// Define INPUT_DEBOUNCER_EVENT_LATCH_EN to make events a sticky, clearable register.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned     WIDTH         = 8,
    parameter int unsigned     STABLE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    input  logic [WIDTH-1:0] event_clear,
    output logic [WIDTH-1:0] events
);

    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        edge_t pulse_next;

        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_BIT     (RESET_VALUE[i])
        ) u_bit (
            .clock      (clock),
            .reset      (reset),
            .in         (in[i]),
            .out        (out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .pulse_next (pulse_next)
        );

        assign rise_next[i] = pulse_next.rise;
        assign fall_next[i] = pulse_next.fall;
    end

    // Built from the same next-state terms so it lines up with rise/fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) changed <= 1'b0;
        else        changed <= |(rise_next | fall_next);
    end

`ifdef INPUT_DEBOUNCER_EVENT_LATCH_EN
    // Set wins over a coincident clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) events <= '0;
        else        events <= (events & ~event_clear) | rise_next | fall_next;
    end
`else
    assign events = rise | fall;

    logic unused_event_clear;
    assign unused_event_clear = ^event_clear;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with WIDTH=8, STABLE_CYCLES=4, 2ns clock.
`timescale 1ns/100ps
module tb_input_debouncer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic [7:0] out, rise, fall, events, event_clear;
    logic       changed;
    logic [24:0] obs, exp;
    int checks = 0;
    int errors = 0;

    input_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .RESET_VALUE(8'h00)) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in),
        .out         (out),
        .rise        (rise),
        .fall        (fall),
        .changed     (changed),
        .event_clear (event_clear),
        .events      (events)
    );

    always #1 clock = ~clock;

    assign obs = {out, rise, fall, changed};

    task automatic tick();
        @(posedge clock);
        #0.5;
    endtask

    task automatic do_reset();
        in = 8'h00;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in = 8'hFF;
        event_clear = 8'h00;
        tick();
        tick();
        checks++;
        if (obs !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            errors++; $display("FAIL reset_state got %h want %h", obs, {8'h00, 8'h00, 8'h00, 1'b0});
        end
        checks++;
        if (events !== 8'h00) begin
            errors++; $display("FAIL reset_events got %h want 00", events);
        end
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 4)       exp = {8'h00, 8'h00, 8'h00, 1'b0};
            else if (k == 4) exp = {8'hFF, 8'hFF, 8'h00, 1'b1};
            else             exp = {8'hFF, 8'h00, 8'h00, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL release_edge%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        in = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (obs !== 25'h0) begin
                errors++; $display("FAIL glitch_hi%0d got %h want 0", k, obs);
            end
        end
        in = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (obs !== 25'h0) begin
                errors++; $display("FAIL glitch_lo%0d got %h want 0", k, obs);
            end
        end
    endtask

    task automatic test_fall();
        in = 8'h01;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (obs !== {8'h01, 8'h01, 8'h00, 1'b1}) begin
            errors++; $display("FAIL fall_setup got %h want %h", obs, {8'h01, 8'h01, 8'h00, 1'b1});
        end
        in = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 4)       exp = {8'h01, 8'h00, 8'h00, 1'b0};
            else if (k == 4) exp = {8'h00, 8'h00, 8'h01, 1'b1};
            else             exp = {8'h00, 8'h00, 8'h00, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL fall_edge%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_independence();
        in = 8'h01;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 1) in = 8'h03;
            case (k)
                3:       exp = {8'h01, 8'h01, 8'h00, 1'b1};
                4:       exp = {8'h01, 8'h00, 8'h00, 1'b0};
                5:       exp = {8'h03, 8'h02, 8'h00, 1'b1};
                6:       exp = {8'h03, 8'h00, 8'h00, 1'b0};
                default: exp = {8'h00, 8'h00, 8'h00, 1'b0};
            endcase
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL indep_edge%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        in = 8'h02;
        for (int k = 1; k <= 3; k++) tick();
        #0.3 reset = 1'b0;
        tick();
        checks++;
        if (obs !== 25'h0) begin
            errors++; $display("FAIL midrst_held got %h want 0", obs);
        end
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = (k == 4) ? {8'h02, 8'h02, 8'h00, 1'b1} : 25'h0;
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL midrst_edge%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_events();
        logic [7:0] ev_exp;
        do_reset();
        in = 8'h04;
        for (int k = 1; k <= 6; k++) begin
            tick();
`ifdef INPUT_DEBOUNCER_EVENT_LATCH_EN
            ev_exp = (k >= 4) ? 8'h04 : 8'h00;
`else
            ev_exp = (k == 4) ? 8'h04 : 8'h00;
`endif
            checks++;
            if (events !== ev_exp) begin
                errors++; $display("FAIL ev_rise%0d got %h want %h", k, events, ev_exp);
            end
        end
        in = 8'h00;
        for (int k = 1; k <= 3; k++) tick();
        event_clear = 8'h04;
        tick();
        checks++;
        if (fall !== 8'h04) begin
            errors++; $display("FAIL ev_fall_pulse got %h want 04", fall);
        end
        checks++;
        if (events !== 8'h04) begin
            errors++; $display("FAIL ev_set_wins got %h want 04", events);
        end
        tick();
        event_clear = 8'h00;
        checks++;
        if (events !== 8'h00) begin
            errors++; $display("FAIL ev_cleared got %h want 00", events);
        end
        tick();
        checks++;
        if (events !== 8'h00) begin
            errors++; $display("FAIL ev_stays_clear got %h want 00", events);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_fall();
        test_independence();
        test_reset_mid_count();
        test_events();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Consumes the WIDTH-bit output of the synchronizer and filters contact bounce and glitches on a per-bit basis.
- Each output bit takes a new value only after the synchronized input has held that value for STABLE_CYCLES consecutive clocks.
- Also generates one-cycle rise and fall pulses, plus an event view for downstream control logic such as a button/switch register block or an IRQ source.

Parameters:
- WIDTH, 8, number of independent input bits
- STABLE_CYCLES, 1000, consecutive differing samples required before a bit changes; legal range 1..2^24
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out on reset

Ports:
- clock  input  1  single system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in  input  WIDTH  already-synchronized inputs (synchronizer out)
- out  output  WIDTH  debounced level
- rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1
- fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0
- changed  output  1  OR-reduction of rise|fall
- event_clear  input  WIDTH  per-bit clear for latched events
- events  output  WIDTH  event view (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset==0, asynchronous assert): out=RESET_VALUE, all counters=0, rise=fall=0, changed=0, events=0.
- Deassertion is expected to be synchronous to clock upstream; no internal reset synchronizer.
- Per bit i, there is a counter cnt[i] of width CNT_W=$clog2(STABLE_CYCLES+1).
- Each rising edge evaluates bit i as follows:
  - in[i]==out[i]: cnt[i]<=0; no pulse.
  - in[i]!=out[i] and cnt[i]<STABLE_CYCLES-1: cnt[i]<=cnt[i]+1.
  - in[i]!=out[i] and cnt[i]==STABLE_CYCLES-1: out[i]<=in[i]; cnt[i]<=0; rise[i]<=in[i]; fall[i]<=~in[i].
- Latency: if in[i] differs from out[i] at sampling edges e1..eN (N=STABLE_CYCLES), out[i] and the matching pulse update at eN.
- For STABLE_CYCLES=1, out is a one-cycle registered copy of in.
- Any single edge where in[i]==out[i] restarts the count: a glitch of fewer than N samples produces no output change and no pulse.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- rise/fall are registered and high for exactly one cycle. They are never both set for the same bit.
- A new transition cannot be accepted on the cycle following a pulse until N fresh differing samples are seen.
- Bits are fully independent; several bits may pulse in the same cycle.
- changed is registered alongside rise/fall.
- Reset mid-count discards partial counts; a full N samples are required after release.
- STABLE_CYCLES==0 is illegal; simulation issues $error at elaboration.

Optional Feature:
- Macro: INPUT_DEBOUNCER_EVENT_LATCH_EN.
- Defined:
  - events is a sticky register.
  - On each edge: events[i] <= (events[i] & ~event_clear[i]) | rise[i]-next | fall[i]-next.
  - If a new pulse and event_clear hit the same bit in the same cycle, set wins.
  - Cleared by reset.
- Undefined:
  - events = rise | fall (combinational copy of the registered pulses).
  - event_clear is ignored; it remains a port and is tied off by the integrator.

Decomposition:
- Shared utils package/header holds:
  - the CNT_W width function (clog2 wrapper);
  - the STABLE_CYCLES range-check constant.
- Natural sub-module is debounce_bit: one counter plus the out/rise/fall flops for one bit, with parameters STABLE_CYCLES and RESET_BIT.
- input_debouncer instantiates WIDTH debounce_bit copies via generate, then adds the changed reduction and the event logic.

Test Plan (bench uses WIDTH=8, STABLE_CYCLES=4, clock period 2ns):
1. Hold reset=0 with in=8'hFF -> out=8'h00, rise=fall=8'h00, events=0. Release reset with in held at FF -> out=8'hFF at the 4th rising edge; rise=8'hFF and changed=1 for exactly one cycle.
2. Glitch: out=8'h00, in=8'h01 for 3 edges then 8'h00 -> out stays 8'h00; rise, fall and changed never assert.
3. Fall: out=8'h01, in=8'h00 held -> out=8'h00 at the 4th edge; fall=8'h01 for one cycle; rise=0.
4. Independence: bit0 goes high at edge 0, bit1 goes high at edge 2 -> out[0] updates at edge 3 and out[1] at edge 5, each with its own single-cycle rise.
5. Reset mid-count: in=8'h02 for 3 edges, assert reset, release -> out stays 8'h00 until 4 further differing edges after release; no early pulse.
6. Event behaviour:
   - Macro defined: rise on bit2 -> events=8'h04 held until event_clear=8'h04 clears it. Clear coincident with a new fall on bit2 -> events[2] remains 1.
   - Macro undefined: events tracks rise|fall cycle-for-cycle.
